mul_seq: RTL and testbench



---
 rtl/mul_seq.sv | 168 ++++++++++++++++
 tb/tb_mul_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Iterative 32x32 -> 64-bit shift-add multiplier driving a 32-bit CLA adder, one add per cycle.
// Optional signed operation (extra signed_op port, FIX state) is enabled with `define MUL_SIGNED_EN.

module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH:0]   w_c;

    assign w_g    = a & b;
    assign w_p    = a ^ b;
    assign w_c[0] = cin;

    // 4-bit lookahead groups; group carries ripple between groups.
    for (genvar k = 0; k < WIDTH / 4; k++) begin : g_grp
        localparam int B = 4 * k;
        assign w_c[B+1] = w_g[B] | (w_p[B] & w_c[B]);
        assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_c[B]);
        assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
        assign w_c[B+4] = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                        | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
    end

    assign s    = w_p ^ w_c[WIDTH-1:0];
    assign cout = w_c[WIDTH];
endmodule

module mul_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef MUL_SIGNED_EN
    input  logic               signed_op,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   w_add_b;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [2*WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0]   w_m_load;
    logic [WIDTH-1:0]   w_lo_load;

`ifdef MUL_SIGNED_EN
    logic               r_neg;
    logic               r_signed;
    logic [2*WIDTH-1:0] w_prod_u;

    // |0x80000000| wraps to 0x80000000, which is still the right unsigned magnitude.
    assign w_m_load  = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_lo_load = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign w_prod_u  = {r_acc_hi, r_acc_lo};
`else
    assign w_m_load  = a;
    assign w_lo_load = b;
`endif

    assign w_add_b   = r_acc_lo[0] ? r_m : '0;
    assign w_shifted = {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};

    adder #(.WIDTH(WIDTH)) u_adder (
        .a    (r_acc_hi),
        .b    (w_add_b),
        .cin  (1'b0),
        .s    (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_m      <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
`ifdef MUL_SIGNED_EN
            r_neg    <= 1'b0;
            r_signed <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_m      <= w_m_load;
                        r_acc_hi <= '0;
                        r_acc_lo <= w_lo_load;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= S_RUN;
`ifdef MUL_SIGNED_EN
                        r_signed <= signed_op;
                        r_neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    {r_acc_hi, r_acc_lo} <= w_shifted;
                    r_cnt                <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef MUL_SIGNED_EN
                        if (r_signed) begin
                            r_state <= S_FIX;
                        end else begin
                            product <= w_shifted;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end
`else
                        product <= w_shifted;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
`endif
                    end
                end
`ifdef MUL_SIGNED_EN
                S_FIX: begin
                    product <= r_neg ? (~w_prod_u + 1'b1) : w_prod_u;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
`endif
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: vector table plus hand sequences for overlap, back-to-back and reset abort.
// Build with +define+MUL_SIGNED_EN to add the signed vectors.

module tb_mul_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;
`ifdef MUL_SIGNED_EN
    logic        signed_op;
`endif

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_prod;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mul_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef MUL_SIGNED_EN
        .signed_op (signed_op),
`endif
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 of the operation.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Waits for done starting from cycle cyc0, then checks latency and product.
    task automatic wait_done(input string name, input int cyc0, input int lat);
        int cyc;
        logic [63:0] exp;
        cyc = cyc0;
        check({name, "_busy"}, {63'd0, busy}, 64'd1);
        while (!done && cyc < cyc0 + 100) begin
            @(negedge clk);
            cyc++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        check({name, "_done"}, {63'd0, done}, 64'd1);
        check({name, "_lat"}, 64'(cyc), 64'(lat));
        check({name, "_prod"}, product, exp);
        check({name, "_busy_off"}, {63'd0, busy}, 64'd0);
        last_prod = exp;
    endtask

    initial begin
        int seen;

        vecs.push_back('{32'd3,         32'd5,         1'b0, 64'h0000_0000_0000_000F});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001});
        vecs.push_back('{32'd0,         32'h0001_2345, 1'b0, 64'h0});
        vecs.push_back('{32'd1,         32'hFFFF_FFFF, 1'b0, 64'h0000_0000_FFFF_FFFF});
        vecs.push_back('{32'h8000_0000, 32'd2,         1'b0, 64'h0000_0001_0000_0000});
        vecs.push_back('{32'h1234_5678, 32'h10,        1'b0, 64'h0000_0001_2345_6780});
        vecs.push_back('{32'hFFFF_FFFF, 32'd2,         1'b0, 64'h0000_0001_FFFF_FFFE});
        vecs.push_back('{32'hDEAD_BEEF, 32'd1,         1'b0, 64'h0000_0000_DEAD_BEEF});
`ifdef MUL_SIGNED_EN
        vecs.push_back('{32'hFFFF_FFFD, 32'd7,         1'b1, 64'hFFFF_FFFF_FFFF_FFEB});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000});
        vecs.push_back('{32'd5,         32'hFFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001});
        signed_op = 1'b0;
`endif

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        last_prod = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_prod", product, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
`ifdef MUL_SIGNED_EN
            signed_op = vecs[i].sgn;
`endif
            exp_q.push_back(vecs[i].exp);
            issue(vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_hold", i), product, last_prod);
            wait_done($sformatf("v%0d", i), 1, vecs[i].sgn ? 34 : 33);
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), {63'd0, done}, 64'd0);
        end
`ifdef MUL_SIGNED_EN
        signed_op = 1'b0;
`endif

        // Start while busy must be ignored.
        exp_q.push_back(64'd4);
        issue(32'd2, 32'd2);
        repeat (9) @(negedge clk);
        start = 1'b1;
        a     = 32'd7;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", 11, 33);
        @(negedge clk);

        // Back-to-back: start asserted during the done cycle.
        exp_q.push_back(64'd42);
        issue(32'd6, 32'd7);
        wait_done("b2b_a", 1, 33);
        exp_q.push_back(64'h0000_0001_0000_0000);
        issue(32'h0001_0000, 32'h0001_0000);
        check("b2b_done_fall", {63'd0, done}, 64'd0);
        check("b2b_hold", product, 64'd42);
        wait_done("b2b_b", 1, 33);
        @(negedge clk);

        // Reset mid-run aborts with no done pulse.
        issue(32'd9, 32'd9);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_prod", product, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_prod = '0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        check("abort_idle", {63'd0, busy}, 64'd0);
        exp_q.push_back(64'd143);
        issue(32'd11, 32'd13);
        wait_done("after_rst", 1, 33);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
